// File: rtl/sqrt_client_if.sv
// Handshake bundle between sqrt_client, its operand source,
// the square-root unit and the result consumer.
interface sqrt_client_if;
  logic        op_valid;
  logic [31:0] op_data;
  logic        op_ready;
  logic [31:0] sq_in;
  logic        sq_start;
  logic        sq_available;
  logic        sq_done;
  logic [31:0] sq_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  modport slave (
    input  op_valid, op_data,
    input  sq_available, sq_done, sq_out,
    input  res_ready,
    output op_ready, sq_in, sq_start,
    output res_valid, res_data, res_err, busy
  );

  modport master (
    output op_valid, op_data,
    output sq_available, sq_done, sq_out,
    output res_ready,
    input  op_ready, sq_in, sq_start,
    input  res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/sqrt_client.sv
// Buffers radicands, drives one sqrt unit op at a time, holds result.
// Optional macro SQRT_CHECK_EN adds a 64-bit result sanity check.
module sqrt_client #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input logic         clk,
  input logic         rstn,
  sqrt_client_if.slave io_bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT_DONE, S_RELEASE, S_OUT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_sq_in;
  logic [31:0]   r_res_data;
  logic          r_sq_start;
  logic          r_res_err;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_tmo;
  logic          w_chk_fail;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = io_bus.op_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty &&
                   io_bus.sq_available;
  assign w_tmo   = (r_timer == TMO);

`ifdef SQRT_CHECK_EN
  logic [63:0] w_r;
  logic [63:0] w_x;
  logic [63:0] w_lo;
  logic [63:0] w_hi;
  assign w_r  = {32'd0, r_res_data};
  assign w_x  = {32'd0, r_sq_in};
  assign w_lo = w_r * w_r;
  assign w_hi = (w_r + 64'd1) * (w_r + 64'd1);
  // (r+1)^2 wraps only for r >= 2^32-1, where r*r > x fails anyway
  assign w_chk_fail = !((w_lo <= w_x) && (w_x < w_hi));
`else
  assign w_chk_fail = 1'b0;
`endif

  assign io_bus.op_ready  = !w_full;
  assign io_bus.sq_in     = r_sq_in;
  assign io_bus.sq_start  = r_sq_start;
  assign io_bus.res_valid = (r_state == S_OUT);
  assign io_bus.res_data  = r_res_data;
  assign io_bus.res_err   = r_res_err;
  assign io_bus.busy      = (r_state != S_IDLE) || !w_empty;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_pop) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (io_bus.sq_done || w_tmo)
                     w_next = S_RELEASE;
      S_RELEASE:   if (!io_bus.sq_done && io_bus.sq_available)
                     w_next = S_OUT;
      S_OUT:       if (io_bus.res_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // operand storage; pointers decide validity so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= io_bus.op_data;
  end

  // FIFO pointers, sqrt-unit request and result registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_timer    <= '0;
      r_sq_in    <= '0;
      r_sq_start <= 1'b0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sq_in    <= r_mem[r_rd_ptr[AW-1:0]];
            r_sq_start <= 1'b1;
            r_timer    <= '0;
          end
        end
        S_WAIT_DONE: begin
          if (io_bus.sq_done) begin
            r_res_data <= io_bus.sq_out;
            r_res_err  <= 1'b0;
            r_sq_start <= 1'b0;
          end else if (w_tmo) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
            r_sq_start <= 1'b0;
          end else if (r_timer != TMAX) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RELEASE: begin
          if (w_chk_fail) r_res_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_client.sv
// Randomized bench for sqrt_client with a behavioural sqrt unit
// and an integer square-root reference.
module tb_sqrt_client;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sqrt_client_if bus();

  sqrt_client #(
    .FIFO_DEPTH(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .io_bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit u_hang = 0;
  bit u_block = 0;
  int u_bias = 0;
  int u_lat_max = 3;
  bit u_busy = 0;
  int u_cnt = 0;
  int n_rise = 0;
  logic prev_start = 1'b0;

`ifdef SQRT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid;
    end
    return 32'(lo);
  endfunction

  assign bus.sq_available = !u_busy && !u_block;

  always @(posedge clk) begin
    if (!rstn) begin
      u_busy      <= 1'b0;
      bus.sq_done <= 1'b0;
      bus.sq_out  <= 32'd0;
    end else if (u_busy) begin
      if (bus.sq_done) begin
        bus.sq_done <= 1'b0;
        u_busy      <= 1'b0;
      end else if (u_cnt > 1) begin
        u_cnt <= u_cnt - 1;
      end else begin
        bus.sq_done <= 1'b1;
        bus.sq_out  <= 32'(isqrt(bus.sq_in) + u_bias);
      end
    end else if (bus.sq_start && bus.sq_available && !u_hang) begin
      u_busy <= 1'b1;
      u_cnt  <= $urandom_range(1, u_lat_max);
    end
  end

  always @(posedge clk) begin
    prev_start <= bus.sq_start;
    if (bus.sq_start && !prev_start) n_rise <= n_rise + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_data = 32'd0;
    bus.res_ready = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] v);
    int n;
    bus.op_valid = 1'b1;
    bus.op_data = v;
    n = 0;
    while (!bus.op_ready && n < 2000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!bus.op_ready) begin
      n_bad++;
      $display("FAIL push_wait op_ready=%0b required 1", bus.op_ready);
    end
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic get_result(input int hold,
                            output logic [31:0] d,
                            output logic e,
                            output bit start_rel,
                            output int start_cyc);
    int n;
    bit prev_done;
    n = 0;
    prev_done = 0;
    start_rel = 0;
    start_cyc = 0;
    while (!bus.res_valid && n < 2000) begin
      if (prev_done && bus.sq_start) start_rel = 1;
      if (bus.sq_start) start_cyc++;
      prev_done = bus.sq_done;
      tick();
      n++;
    end
    n_cmp++;
    if (!bus.res_valid) begin
      n_bad++;
      $display("FAIL result_wait res_valid=%0b required 1", bus.res_valid);
    end
    repeat (hold) tick();
    d = bus.res_data;
    e = bus.res_err;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 7;
    if (bus.op_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_op_ready got %b exp 1", bus.op_ready);
    end
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got %b exp 0", bus.busy);
    end
    if (bus.sq_start !== 1'b0) begin
      n_bad++; $display("FAIL rst_sq_start got %b exp 0", bus.sq_start);
    end
    if (bus.sq_in !== 32'd0) begin
      n_bad++; $display("FAIL rst_sq_in got %h exp 0", bus.sq_in);
    end
    if (bus.res_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_res_valid got %b exp 0", bus.res_valid);
    end
    if (bus.res_data !== 32'd0) begin
      n_bad++; $display("FAIL rst_res_data got %h exp 0", bus.res_data);
    end
    if (bus.res_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_res_err got %b exp 0", bus.res_err);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    push(32'd16);
    get_result(0, d, e, sr, sc);
    n_cmp += 3;
    if (d !== 32'd4) begin
      n_bad++; $display("FAIL basic_data got %0d exp 4", d);
    end
    if (e !== 1'b0) begin
      n_bad++; $display("FAIL basic_err got %b exp 0", e);
    end
    if (sr !== 1'b0) begin
      n_bad++; $display("FAIL basic_start_in_release got %b exp 0", sr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    int r0;
    r0 = n_rise;
    push(32'd1000000);
    push(32'hFFFF_FFFF);
    get_result(0, d, e, sr, sc);
    n_cmp += 2;
    if (d !== 32'd1000 || e !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first got %0d/%b exp 1000/0", d, e);
    end
    if (sr !== 1'b0) begin
      n_bad++; $display("FAIL b2b_start_in_release got 1 exp 0");
    end
    get_result(1, d, e, sr, sc);
    n_cmp += 2;
    if (d !== 32'd65535 || e !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second got %0d/%b exp 65535/0", d, e);
    end
    if (n_rise - r0 !== 2) begin
      n_bad++; $display("FAIL b2b_start_pulses got %0d exp 2", n_rise - r0);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] ops[5];
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    u_block = 1;
    foreach (ops[i]) ops[i] = $urandom;
    for (int i = 0; i < 4; i++) push(ops[i]);
    n_cmp += 2;
    if (bus.op_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_op_ready got %b exp 0", bus.op_ready);
    end
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL full_busy got %b exp 1", bus.busy);
    end
    bus.op_valid = 1'b1;
    bus.op_data = ops[4];
    repeat (3) tick();
    n_cmp++;
    if (bus.op_ready !== 1'b0 || bus.sq_start !== 1'b0) begin
      n_bad++;
      $display("FAIL full_hold op_ready=%b sq_start=%b exp 0/0",
               bus.op_ready, bus.sq_start);
    end
    u_block = 0;
    push(ops[4]);
    for (int i = 0; i < 5; i++) begin
      get_result($urandom_range(0, 2), d, e, sr, sc);
      n_cmp++;
      if (d !== isqrt(ops[i]) || e !== 1'b0) begin
        n_bad++;
        $display("FAIL full_result%0d got %0d/%b exp %0d/0",
                 i, d, e, isqrt(ops[i]));
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    u_hang = 1;
    push($urandom);
    get_result(0, d, e, sr, sc);
    u_hang = 0;
    n_cmp += 3;
    if (d !== 32'd0) begin
      n_bad++; $display("FAIL tmo_data got %0d exp 0", d);
    end
    if (e !== 1'b1) begin
      n_bad++; $display("FAIL tmo_err got %b exp 1", e);
    end
    if (sc !== 256) begin
      n_bad++; $display("FAIL tmo_wait_cycles got %0d exp 256", sc);
    end
  endtask

  task automatic test_check();
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    u_bias = 1;
    push(32'd16);
    get_result(0, d, e, sr, sc);
    u_bias = 0;
    n_cmp += 2;
    if (d !== 32'd5) begin
      n_bad++; $display("FAIL check_data got %0d exp 5", d);
    end
    if (e !== CHK) begin
      n_bad++; $display("FAIL check_err got %b exp %b", e, CHK);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] x;
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    int k;
    u_lat_max = 5;
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        case ($urandom_range(0, 2))
          0: x = $urandom;
          1: x = $urandom_range(0, 300);
          default: begin
            x = $urandom_range(0, 65535);
            x = x * x;
          end
        endcase
        q.push_back(x);
        push(x);
      end
      while (q.size() > 0) begin
        x = q.pop_front();
        get_result($urandom_range(0, 3), d, e, sr, sc);
        n_cmp++;
        if (d !== isqrt(x) || e !== 1'b0) begin
          n_bad++;
          $display("FAIL rand x=%0d got %0d/%b exp %0d/0",
                   x, d, e, isqrt(x));
        end
      end
    end
    u_lat_max = 3;
  endtask

  task automatic test_reset_mid();
    logic [31:0] x;
    logic [31:0] d;
    logic e;
    bit sr;
    int sc;
    int n;
    x = $urandom;
    push(x);
    n = 0;
    while (!bus.res_valid && n < 2000) begin
      tick();
      n++;
    end
    push($urandom);
    push($urandom);
    repeat (10) tick();
    n_cmp += 2;
    if (bus.res_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_hold_valid got %b exp 1", bus.res_valid);
    end
    if (bus.res_data !== isqrt(x)) begin
      n_bad++;
      $display("FAIL mid_hold_data got %0d exp %0d", bus.res_data, isqrt(x));
    end
    rstn = 1'b0;
    tick();
    n_cmp += 4;
    if (bus.res_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_valid got %b exp 0", bus.res_valid);
    end
    if (bus.sq_start !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_start got %b exp 0", bus.sq_start);
    end
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_busy got %b exp 0", bus.busy);
    end
    if (bus.op_ready !== 1'b1 || bus.res_data !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_rst_state op_ready=%b res_data=%0d exp 1/0",
               bus.op_ready, bus.res_data);
    end
    rstn = 1'b1;
    tick();
    push(32'd49);
    get_result(0, d, e, sr, sc);
    n_cmp++;
    if (d !== 32'd7 || e !== 1'b0) begin
      n_bad++; $display("FAIL mid_after got %0d/%b exp 7/0", d, e);
    end
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_data = 32'd0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_check();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sqrt_client.md
SQRT_CLIENT -- requirements
Module: sqrt_client

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for sq_done before error.
REQ-003 clk input 1 rising-edge clock for all state.
REQ-004 rstn input 1 reset, synchronous, active-low.
REQ-005 op_valid input 1 upstream operand present.
REQ-006 op_data input 32 unsigned radicand.
REQ-007 op_ready output 1 FIFO can accept operand.
REQ-008 sq_in output 32 radicand to sqrt unit.
REQ-009 sq_start output 1 START request to sqrt unit.
REQ-010 sq_available input 1 sqrt unit idle, may be started.
REQ-011 sq_done input 1 sqrt unit result valid.
REQ-012 sq_out input 32 sqrt unit result.
REQ-013 res_valid output 1 result held for downstream.
REQ-014 res_ready input 1 downstream accepts result.
REQ-015 res_data output 32 square root result.
REQ-016 res_err output 1 result invalid (timeout or check failure).
REQ-017 busy output 1 FSM not IDLE or FIFO non-empty.

Function
REQ-018 Operand accepted on clock edge where op_valid&&op_ready; op_ready = FIFO not full (no same-cycle pop credit).
REQ-019 FIFO pop only in IDLE->WAIT_DONE transition; pop and push same cycle both occur, count unchanged.
REQ-020 FSM states IDLE, WAIT_DONE, RELEASE, OUT.
REQ-021 IDLE: FIFO non-empty && sq_available -> register sq_in=head, sq_start=1, pop, clear timer, go WAIT_DONE; else stay, sq_start=0.
REQ-022 WAIT_DONE: sq_start held 1, sq_in held stable; sq_done=1 -> capture sq_out into res_data, res_err=0, go RELEASE.
REQ-023 WAIT_DONE: timer increments each cycle; timer==TIMEOUT without sq_done -> res_data=0, res_err=1, go RELEASE.
REQ-024 RELEASE: sq_start=0; stay until sq_done=0 and sq_available=1, then go OUT.
REQ-025 OUT: res_valid=1, res_data/res_err stable; res_ready=1 -> res_valid=0 next cycle, go IDLE.
REQ-026 Minimum operand-to-result latency: push cycle + 1 (IDLE) + unit latency + 1 (RELEASE) + 1 (OUT).
REQ-027 Only one operation outstanding at the sqrt unit; sq_start never asserted while sq_available=0 in IDLE.
REQ-028 Timer 8 bits wide minimum, saturating; TIMEOUT=0 means error on first WAIT_DONE cycle lacking sq_done.

Reset
REQ-029 rstn=0 at clock edge: FSM=IDLE, FIFO empty, sq_start=0, sq_in=0, res_valid=0, res_data=0, res_err=0, timer=0.
REQ-030 Reset mid-operation discards FIFO contents and in-flight result; sq_start deasserted on the reset edge.
REQ-031 op_ready=1, busy=0 from the cycle after reset release.

Configuration
REQ-032 Macro SQRT_CHECK_EN defined: in RELEASE, verify r=res_data against radicand x using 64-bit arithmetic (r*r <= x < (r+1)*(r+1)); failure sets res_err=1, res_data unchanged.
REQ-033 SQRT_CHECK_EN undefined: no check logic; res_err set by timeout only.

Verification
REQ-034 Push 16, unit returns 4 -> res_data=4, res_err=0, sq_start low in RELEASE.
REQ-035 Push 1000000, 0xFFFFFFFF back-to-back -> results 1000 then 65535 in order, one sq_start pulse per operand.
REQ-036 Hold sq_available=0, push 5 operands -> op_ready low after 4th, 5th held until pop.
REQ-037 sq_done never asserted, TIMEOUT=255 -> res_valid after 256 WAIT_DONE cycles, res_data=0, res_err=1.
REQ-038 SQRT_CHECK_EN, push 16, unit returns 5 -> res_err=1, res_data=5; undefined -> res_err=0.
REQ-039 res_ready low 10 cycles in OUT, then rstn=0 -> res_valid=0, FIFO empty, sq_start=0 next edge.
